id_ex_pipe_reg: RTL and testbench

- ID/EX pipeline register for the 5-stage RV64 core, with integrated load-use hazard detection and bubble/flush insertion.
- Sits between decode/register-file read and EX.
- Drives IDEX_rs1/IDEX_rs2/IDEX_rd and control into the forwarding unit and the ALU operand muxes.
- Drives stall back to the PC and the IF/ID register.

---
 rtl/id_ex_pipe_reg_pkg.sv | 18 +
 rtl/id_ex_pipe_reg_load_use_detect.sv | 22 ++
 rtl/id_ex_pipe_reg.sv | 119 +++++++++++
 tb/tb_id_ex_pipe_reg.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared definitions for the ID/EX stage: control-byte bit positions and the
// all-zero bubble encoding used whenever a slot is squashed.
package id_ex_pipe_reg_pkg;

    localparam int CTRL_W        = 8;
    localparam int CTRL_REGWRITE = 7;
    localparam int CTRL_MEMREAD  = 6;
    localparam int CTRL_MEMWRITE = 5;
    localparam int CTRL_MEMTOREG = 4;
    localparam int CTRL_ALUSRC   = 3;
    localparam int CTRL_BRANCH   = 2;
    localparam int CTRL_ALUOP_HI = 1;
    localparam int CTRL_ALUOP_LO = 0;

    // A bubble carries no RegWrite/MemWrite/Branch, so downstream sees no side effects.
    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = 8'h00;

endpackage

// File: rtl/id_ex_pipe_reg_load_use_detect.sv
// Load-use hazard detector: flags when the instruction in ID reads a register
// that the load currently in EX has not yet produced. Pure combinational so an
// IF/ID stage can reuse it. x0 is never a hazard.
module load_use_detect #(
    parameter int REG_AW = 5
) (
    input  logic              idex_valid,
    input  logic              idex_memread,
    input  logic [REG_AW-1:0] idex_rd,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    output logic              hz
);

    // Hazard equation: a live load in EX targeting a non-zero register read by ID.
    always_comb begin
        hz = idex_valid & idex_memread & (idex_rd != '0) & id_valid &
             ((idex_rd == id_rs1) | (idex_rd == id_rs2));
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use stall and bubble/flush insertion.
// Optional macro HAZARD_PERF_EN adds saturating stall/flush event counters.
//
// Valid semantics: IDEX_valid=1 means the EX slot holds a real instruction.
// There is no ready; the upstream stages honour stall by holding PC and IF/ID,
// and this stage inserts a bubble (valid=0, ctrl=0, all fields 0) in its place.
module id_ex_pipe_reg
    import id_ex_pipe_reg_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [XLEN-1:0]   id_rdata1,
    input  logic [XLEN-1:0]   id_rdata2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [3:0]        id_funct4,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              ex_flush,
    output logic              stall,
    output logic              IDEX_valid,
    output logic [XLEN-1:0]   IDEX_pc,
    output logic [XLEN-1:0]   IDEX_rdata1,
    output logic [XLEN-1:0]   IDEX_rdata2,
    output logic [XLEN-1:0]   IDEX_imm,
    output logic [REG_AW-1:0] IDEX_rs1,
    output logic [REG_AW-1:0] IDEX_rs2,
    output logic [REG_AW-1:0] IDEX_rd,
    output logic [3:0]        IDEX_funct4,
    output logic [CTRL_W-1:0] IDEX_ctrl
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    logic hz;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_load_use_detect (
        .idex_valid   (IDEX_valid),
        .idex_memread (IDEX_ctrl[CTRL_MEMREAD]),
        .idex_rd      (IDEX_rd),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .hz           (hz)
    );

    // A flush squashes the wrong-path ID instruction, so it never needs to stall.
    always_comb begin
        stall = hz & ~ex_flush;
    end

    // Pipeline register: flush or hazard inserts a bubble, otherwise capture ID.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            IDEX_valid  <= 1'b0;
            IDEX_pc     <= '0;
            IDEX_rdata1 <= '0;
            IDEX_rdata2 <= '0;
            IDEX_imm    <= '0;
            IDEX_rs1    <= '0;
            IDEX_rs2    <= '0;
            IDEX_rd     <= '0;
            IDEX_funct4 <= '0;
            IDEX_ctrl   <= CTRL_BUBBLE;
        end else if (ex_flush || hz) begin
            IDEX_valid  <= 1'b0;
            IDEX_pc     <= '0;
            IDEX_rdata1 <= '0;
            IDEX_rdata2 <= '0;
            IDEX_imm    <= '0;
            IDEX_rs1    <= '0;
            IDEX_rs2    <= '0;
            IDEX_rd     <= '0;
            IDEX_funct4 <= '0;
            IDEX_ctrl   <= CTRL_BUBBLE;
        end else begin
            IDEX_valid  <= id_valid;
            IDEX_pc     <= id_pc;
            IDEX_rdata1 <= id_rdata1;
            IDEX_rdata2 <= id_rdata2;
            IDEX_imm    <= id_imm;
            IDEX_rs1    <= id_rs1;
            IDEX_rs2    <= id_rs2;
            IDEX_rd     <= id_rd;
            IDEX_funct4 <= id_funct4;
            // Gate control on valid so a stale id_ctrl never leaks into EX.
            IDEX_ctrl   <= id_valid ? id_ctrl : CTRL_BUBBLE;
        end
    end

`ifdef HAZARD_PERF_EN
    // Saturating event counters: stall cycles and flushes of a valid ID instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (ex_flush && id_valid && (perf_flush_cnt != 32'hFFFF_FFFF)) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed scenarios with literal
// expectations, then randomized traffic compared against a slot-level model.
module tb_id_ex_pipe_reg;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;

    // What the model believes occupies the EX slot; a bubble is all zeros.
    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rdata1;
        logic [XLEN-1:0]   rdata2;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [3:0]        funct4;
        logic [7:0]        ctrl;
    } slot_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              id_valid;
    logic [XLEN-1:0]   id_pc;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
    logic [XLEN-1:0]   id_rdata1, id_rdata2, id_imm;
    logic [3:0]        id_funct4;
    logic [7:0]        id_ctrl;
    logic              ex_flush;
    logic              stall;
    logic              IDEX_valid;
    logic [XLEN-1:0]   IDEX_pc, IDEX_rdata1, IDEX_rdata2, IDEX_imm;
    logic [REG_AW-1:0] IDEX_rs1, IDEX_rs2, IDEX_rd;
    logic [3:0]        IDEX_funct4;
    logic [7:0]        IDEX_ctrl;
`ifdef HAZARD_PERF_EN
    logic [31:0]       perf_stall_cnt, perf_flush_cnt;
`endif

    int    checks = 0;
    int    errors = 0;
    slot_t ex;
    int    exp_stall_cnt;
    int    exp_flush_cnt;

    id_ex_pipe_reg #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .id_rdata1   (id_rdata1),
        .id_rdata2   (id_rdata2),
        .id_imm      (id_imm),
        .id_funct4   (id_funct4),
        .id_ctrl     (id_ctrl),
        .ex_flush    (ex_flush),
        .stall       (stall),
        .IDEX_valid  (IDEX_valid),
        .IDEX_pc     (IDEX_pc),
        .IDEX_rdata1 (IDEX_rdata1),
        .IDEX_rdata2 (IDEX_rdata2),
        .IDEX_imm    (IDEX_imm),
        .IDEX_rs1    (IDEX_rs1),
        .IDEX_rs2    (IDEX_rs2),
        .IDEX_rd     (IDEX_rd),
        .IDEX_funct4 (IDEX_funct4),
        .IDEX_ctrl   (IDEX_ctrl)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    // Clock and reset
    always #5 clk = ~clk;

    // Scoreboard compare
    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model rule: a load in EX whose non-x0 destination is read by a valid ID instruction.
    function automatic logic model_hz();
        return ex.valid && ex.ctrl[6] && (ex.rd != 0) && id_valid &&
               ((ex.rd == id_rs1) || (ex.rd == id_rs2));
    endfunction

    task automatic check_all();
        logic exp_stall;
        exp_stall = model_hz() && !ex_flush;
        chk("stall",       {63'd0, stall},       {63'd0, exp_stall});
        chk("IDEX_valid",  {63'd0, IDEX_valid},  {63'd0, ex.valid});
        chk("IDEX_pc",     IDEX_pc,              ex.pc);
        chk("IDEX_rdata1", IDEX_rdata1,          ex.rdata1);
        chk("IDEX_rdata2", IDEX_rdata2,          ex.rdata2);
        chk("IDEX_imm",    IDEX_imm,             ex.imm);
        chk("IDEX_rs1",    XLEN'(IDEX_rs1),      XLEN'(ex.rs1));
        chk("IDEX_rs2",    XLEN'(IDEX_rs2),      XLEN'(ex.rs2));
        chk("IDEX_rd",     XLEN'(IDEX_rd),       XLEN'(ex.rd));
        chk("IDEX_funct4", XLEN'(IDEX_funct4),   XLEN'(ex.funct4));
        chk("IDEX_ctrl",   XLEN'(IDEX_ctrl),     XLEN'(ex.ctrl));
`ifdef HAZARD_PERF_EN
        chk("perf_stall_cnt", XLEN'(perf_stall_cnt), XLEN'(exp_stall_cnt));
        chk("perf_flush_cnt", XLEN'(perf_flush_cnt), XLEN'(exp_flush_cnt));
`endif
    endtask

    // One clock: check outputs, take the edge, advance the model, return at negedge.
    task automatic cycle();
        logic hz;
        logic stl;
        #1;
        check_all();
        hz  = model_hz();
        stl = hz && !ex_flush;
        @(posedge clk);
        if (!reset) begin
            ex = '0;
            exp_stall_cnt = 0;
            exp_flush_cnt = 0;
        end else begin
            if (stl) exp_stall_cnt++;
            if (ex_flush && id_valid) exp_flush_cnt++;
            if (ex_flush || hz) begin
                ex = '0;
            end else begin
                ex.valid  = id_valid;
                ex.pc     = id_pc;
                ex.rdata1 = id_rdata1;
                ex.rdata2 = id_rdata2;
                ex.imm    = id_imm;
                ex.rs1    = id_rs1;
                ex.rs2    = id_rs2;
                ex.rd     = id_rd;
                ex.funct4 = id_funct4;
                ex.ctrl   = id_valid ? id_ctrl : 8'h00;
            end
        end
        @(negedge clk);
    endtask

    // Driver: present one decoded instruction with random data payload.
    task automatic drive_id(input logic v, input logic [XLEN-1:0] pc,
                            input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2,
                            input logic [REG_AW-1:0] rd, input logic [7:0] ctrl);
        id_valid  = v;
        id_pc     = pc;
        id_rs1    = rs1;
        id_rs2    = rs2;
        id_rd     = rd;
        id_ctrl   = ctrl;
        id_rdata1 = {$urandom, $urandom};
        id_rdata2 = {$urandom, $urandom};
        id_imm    = {$urandom, $urandom};
        id_funct4 = 4'($urandom_range(0, 15));
    endtask

    initial begin
        ex = '0;
        exp_stall_cnt = 0;
        exp_flush_cnt = 0;
        ex_flush = 1'b0;
        reset = 1'b0;
        drive_id(1'b1, 64'h40, 5'd1, 5'd2, 5'd3, 8'hFF);
        @(negedge clk);

        // Reset holds everything at zero despite a fully-set ID instruction.
        #1;
        chk("rst_valid", {63'd0, IDEX_valid}, 64'd0);
        chk("rst_ctrl",  XLEN'(IDEX_ctrl), 64'd0);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        cycle();
        cycle();

        // add x5,x1,x2
        reset = 1'b1;
        drive_id(1'b1, 64'h100, 5'd1, 5'd2, 5'd5, 8'h80);
        cycle();
        chk("add_valid", {63'd0, IDEX_valid}, 64'd1);
        chk("add_rd",    XLEN'(IDEX_rd), 64'd5);
        chk("add_ctrl",  XLEN'(IDEX_ctrl), 64'h80);
        chk("add_pc",    IDEX_pc, 64'h100);

        // ld x6 then add x7,x6,x3: one stall, one bubble, then the add
        drive_id(1'b1, 64'h104, 5'd1, 5'd0, 5'd6, 8'hD8);
        cycle();
        drive_id(1'b1, 64'h108, 5'd6, 5'd3, 5'd7, 8'h80);
        #1;
        chk("lu_stall", {63'd0, stall}, 64'd1);
        cycle();
        chk("lu_bub_valid", {63'd0, IDEX_valid}, 64'd0);
        chk("lu_bub_ctrl",  XLEN'(IDEX_ctrl), 64'd0);
        chk("lu_stall_end", {63'd0, stall}, 64'd0);
        cycle();
        chk("lu_add_rs1",   XLEN'(IDEX_rs1), 64'd6);
        chk("lu_add_pc",    IDEX_pc, 64'h108);

        // Load to x0 followed by a read of x0: no stall
        drive_id(1'b1, 64'h10C, 5'd1, 5'd0, 5'd0, 8'hD8);
        cycle();
        drive_id(1'b1, 64'h110, 5'd0, 5'd0, 5'd8, 8'h80);
        #1;
        chk("x0_stall", {63'd0, stall}, 64'd0);
        cycle();
        chk("x0_valid", {63'd0, IDEX_valid}, 64'd1);
        chk("x0_pc",    IDEX_pc, 64'h110);

        // Flush coincident with a load-use hazard: flush wins, no stall
        drive_id(1'b1, 64'h114, 5'd2, 5'd0, 5'd9, 8'hD8);
        cycle();
        drive_id(1'b1, 64'h118, 5'd9, 5'd0, 5'd10, 8'h80);
        ex_flush = 1'b1;
        #1;
        chk("fl_stall", {63'd0, stall}, 64'd0);
        cycle();
        ex_flush = 1'b0;
        chk("fl_valid", {63'd0, IDEX_valid}, 64'd0);
        chk("fl_ctrl",  XLEN'(IDEX_ctrl), 64'd0);
        chk("fl_pc",    IDEX_pc, 64'd0);
`ifdef HAZARD_PERF_EN
        chk("perf_stall_dir", XLEN'(perf_stall_cnt), 64'd1);
        chk("perf_flush_dir", XLEN'(perf_flush_cnt), 64'd1);
`endif

        // Randomized traffic with narrow register ranges to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] c;
            c = 8'($urandom_range(0, 255));
            c[6] = ($urandom_range(0, 1) == 1);
            drive_id($urandom_range(0, 3) != 0, {$urandom, $urandom},
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), c);
            ex_flush = ($urandom_range(0, 9) == 0);
            if (i == 1500) begin
                // Asynchronous reset asserted between edges
                #2;
                reset = 1'b0;
                ex = '0;
                exp_stall_cnt = 0;
                exp_flush_cnt = 0;
                cycle();
                reset = 1'b1;
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
